fu_issue_scheduler: RTL and testbench
=====================================

FU_ISSUE_SCHEDULER -- requirements
Module: fu_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 64, meaning the number of issue-queue entries arbitrated.
REQ-002 SHALL have parameter NUM_FU, default 3, meaning the number of functional units.
REQ-003 SHALL have parameters FU0_LAT, FU1_LAT, FU2_LAT, defaults 1, 1, 3, meaning each unit's occupancy in cycles (legal range 1..7).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_ready, input, NUM_ENTRIES bits: bit i set when entry i is valid and both sources are ready.
REQ-007 SHALL have port req_fu, input, 2*NUM_ENTRIES bits: entry i target unit in bits [2i+1:2i]; code 2'b11 is invalid.
REQ-008 SHALL have port grant_ready, input, 1 bit: the issue queue or execute stage accepts the presented grant.
REQ-009 SHALL have port flush, input, 1 bit: drops any pending grant.
REQ-010 SHALL have port grant_valid, output, 1 bit: a grant is presented.
REQ-011 SHALL have port grant_index, output, 6 bits: the granted entry index.
REQ-012 SHALL have port grant_fu, output, 2 bits: the granted unit.
REQ-013 SHALL have port fu_busy, output, NUM_FU bits: bit f set when busy_cnt[f] is nonzero.

Function
REQ-014 SHALL register all outputs; a request sampled in cycle N yields grant_valid in cycle N+1 at the earliest.
REQ-015 SHALL define fire as grant_valid && grant_ready; the grant outputs SHALL hold stable while grant_valid && !grant_ready.
REQ-016 SHALL load a new grant only when the slot is empty or fire is true; otherwise no selection occurs.
REQ-017 SHALL treat entry i as eligible when req_ready[i] is set, req_fu[i] != 2'b11, unit req_fu[i] is available, and i is not the index currently presented (no re-grant of a pending or firing entry).
REQ-018 SHALL treat unit f as available when busy_cnt[f]==0 and there is no pending unaccepted grant to f; when a grant to f fires in the same cycle, f SHALL be available only if FUf_LAT==1.
REQ-019 SHALL select among eligible entries round-robin: first eligible index at or above rr_ptr, wrapping from NUM_ENTRIES-1 to 0.
REQ-020 SHALL set rr_ptr to (k+1) mod NUM_ENTRIES when entry k is granted; rr_ptr SHALL be unchanged otherwise.
REQ-021 SHALL clear grant_valid in the next cycle when no eligible entry exists and the slot is empty or firing.
REQ-022 SHALL load busy_cnt[f] with FUf_LAT-1 on fire to unit f; otherwise each nonzero busy_cnt SHALL decrement by 1 per cycle, saturating at 0.
REQ-023 SHALL, on flush, clear grant_valid next cycle, suppress the fire and any new selection that cycle, and leave busy_cnt and rr_ptr unchanged.
REQ-024 SHALL issue at most one grant per cycle.
REQ-025 SHALL never present grant_fu == 2'b11.

Reset
REQ-026 SHALL, while reset is high, asynchronously force grant_valid=0, grant_index=0, grant_fu=0, rr_ptr=0, all busy_cnt=0, and fu_busy=0.
REQ-027 SHALL, on reset mid-grant, discard the pending grant with no fire and no counter load; the first grant after reset deasserts SHALL follow REQ-014.

Structure
REQ-028 SHALL take NUM_ENTRIES, NUM_FU, FU_INVALID (2'b11), and the default unit latencies from the shared package ooo_pkg.
REQ-029 SHALL place the wrap-around find-first-from-pointer search in one combinational sub-module, rr_priority_picker (inputs: eligible vector and pointer; outputs: found and index).
REQ-030 SHALL keep all sequential state (grant register, rr_ptr, busy counters) in fu_issue_scheduler.

Verification
REQ-031 SHALL cover: req_ready=bits 3 and 10, both FU0, rr_ptr=0, grant_ready=1 -> grant index 3 one cycle later, index 10 the next cycle, rr_ptr=11.
REQ-032 SHALL cover: rr_ptr=62, requests at entries 1 and 63 -> index 63 granted first, then index 1 (wrap-around).
REQ-033 SHALL cover: grant to FU2 fires (LAT 3), entry 5 requests FU2 -> fu_busy[2] high for 2 cycles, entry 5 granted in the first cycle after fu_busy[2] clears.
REQ-034 SHALL cover: grant_ready=0 for 4 cycles with other requests pending -> grant_index and grant_fu constant; no second grant until fire.
REQ-035 SHALL cover: flush asserted while grant_valid=1 -> grant_valid=0 next cycle, busy_cnt unchanged; entry with req_fu=2'b11 -> never granted.
REQ-036 SHALL cover: reset asserted mid-grant -> outputs 0 immediately without a clock edge; after release, request at entry 0 -> granted one cycle later.

Source files
------------

// File: rtl/ooo_pkg.sv
// ooo_pkg: definitions shared by the out-of-order issue logic.
//   NUM_ENTRIES  - number of issue-queue entries that are arbitrated
//   NUM_FU       - number of functional units
//   IDX_W        - width of an entry index, matching the 6-bit grant_index port
//   FU_INVALID   - unit code that marks an entry as having no legal target
//   FUx_LAT_DEF  - default occupancy of each functional unit, in cycles
package ooo_pkg;

    localparam int NUM_ENTRIES = 64;
    localparam int NUM_FU      = 3;
    localparam int IDX_W       = 6;

    typedef logic [1:0] fu_id_t;

    localparam fu_id_t FU_INVALID = 2'b11;

    localparam int FU0_LAT_DEF = 1;
    localparam int FU1_LAT_DEF = 1;
    localparam int FU2_LAT_DEF = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational wrap-around find-first.
// Returns the lowest set bit of 'eligible' whose position is at or above
// 'ptr'; if there is none, the lowest set bit overall (the wrap).
//   eligible - candidate vector, one bit per entry
//   ptr      - round-robin start position
//   found    - at least one candidate exists
//   index    - selected position (0 when found is low)
module rr_priority_picker #(
    parameter int N = 64,
    parameter int W = 6
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    logic [N-1:0] at_or_above;
    logic [N-1:0] upper;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign at_or_above[gi] = (W'(gi) >= ptr);
        end
    endgenerate

    assign upper = eligible & at_or_above;

    // First loop finds the lowest candidate anywhere (the wrapped choice);
    // the second overrides it with the lowest candidate at/above ptr.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                index = W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (upper[i]) begin
                index = W'(i);
            end
        end
    end

endmodule

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: picks one ready issue-queue entry per cycle,
// round-robin, whose target functional unit is free, and presents it as a
// registered grant held until accepted.
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   req_ready   - per entry: valid with both sources ready
//   req_fu      - per entry 2-bit target unit, entry i in [2i+1:2i]
//   grant_ready - consumer accepts the presented grant
//   flush       - drop the pending grant, no fire, no new selection
//   grant_valid - a grant is presented
//   grant_index - granted entry
//   grant_fu    - granted unit
//   fu_busy     - per unit: occupancy counter nonzero
module fu_issue_scheduler #(
    parameter int NUM_ENTRIES = ooo_pkg::NUM_ENTRIES,
    parameter int NUM_FU      = ooo_pkg::NUM_FU,
    parameter int FU0_LAT     = ooo_pkg::FU0_LAT_DEF,
    parameter int FU1_LAT     = ooo_pkg::FU1_LAT_DEF,
    parameter int FU2_LAT     = ooo_pkg::FU2_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_ENTRIES-1:0]   req_ready,
    input  logic [2*NUM_ENTRIES-1:0] req_fu,
    input  logic                     grant_ready,
    input  logic                     flush,
    output logic                     grant_valid,
    output logic [5:0]               grant_index,
    output logic [1:0]               grant_fu,
    output logic [NUM_FU-1:0]        fu_busy
);

    import ooo_pkg::*;

    localparam int LAT [3] = '{FU0_LAT, FU1_LAT, FU2_LAT};

    logic                   grant_valid_reg;
    logic [IDX_W-1:0]       grant_index_reg;
    fu_id_t                 grant_fu_reg;
    logic [IDX_W-1:0]       rr_ptr_reg;

    logic                   fire;
    logic                   load_slot;
    logic [3:0]             fu_avail;
    logic [NUM_ENTRIES-1:0] eligible;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_index;
    fu_id_t                 pick_fu;
    logic [IDX_W-1:0]       ptr_next;

    // A flush cancels the handshake even if the consumer is ready.
    assign fire      = grant_valid_reg && grant_ready && !flush;
    assign load_slot = !flush && (!grant_valid_reg || fire);

    // Per-unit occupancy counters and availability. A unit with a pending
    // unaccepted grant is held; a unit being fired this cycle is free again
    // only when its occupancy is a single cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fu
            if (gi < NUM_FU) begin : g_real
                logic [2:0] cnt_reg;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cnt_reg <= 3'd0;
                    end else if (fire && grant_fu_reg == 2'(gi)) begin
                        cnt_reg <= 3'(LAT[gi] - 1);
                    end else if (cnt_reg != 3'd0) begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end

                assign fu_busy[gi]  = (cnt_reg != 3'd0);
                assign fu_avail[gi] = (cnt_reg == 3'd0) &&
                                      !(grant_valid_reg && grant_fu_reg == 2'(gi) &&
                                        !(fire && LAT[gi] == 1));
            end else begin : g_none
                assign fu_avail[gi] = 1'b0;
            end
        end
    endgenerate

    // Entry eligibility; the presented entry is excluded so a pending or
    // firing grant is never issued twice.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_elig
            fu_id_t code;
            assign code         = req_fu[2*gi +: 2];
            assign eligible[gi] = req_ready[gi] && (code != FU_INVALID) && fu_avail[code] &&
                                  !(grant_valid_reg && grant_index_reg == IDX_W'(gi));
        end
    endgenerate

    rr_priority_picker #(
        .N (NUM_ENTRIES),
        .W (IDX_W)
    ) u_picker (
        .eligible (eligible),
        .ptr      (rr_ptr_reg),
        .found    (pick_found),
        .index    (pick_index)
    );

    assign pick_fu  = req_fu[2*pick_index +: 2];
    assign ptr_next = (pick_index == IDX_W'(NUM_ENTRIES - 1)) ? '0 : pick_index + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_valid_reg <= 1'b0;
            grant_index_reg <= '0;
            grant_fu_reg    <= '0;
            rr_ptr_reg      <= '0;
        end else if (flush) begin
            grant_valid_reg <= 1'b0;
        end else if (load_slot) begin
            grant_valid_reg <= pick_found;
            if (pick_found) begin
                grant_index_reg <= pick_index;
                grant_fu_reg    <= pick_fu;
                rr_ptr_reg      <= ptr_next;
            end
        end
    end

    assign grant_valid = grant_valid_reg;
    assign grant_index = grant_index_reg;
    assign grant_fu    = grant_fu_reg;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: directed stimulus for fu_issue_scheduler with a
// cycle-level reference model of the arbitration rules and literal
// expectations for the key scenarios.
module tb_fu_issue_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  req_ready;
    logic [127:0] req_fu;
    logic         grant_ready;
    logic         flush;
    logic         grant_valid;
    logic [5:0]   grant_index;
    logic [1:0]   grant_fu;
    logic [2:0]   fu_busy;

    int checks = 0;
    int errors = 0;

    fu_issue_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .req_ready   (req_ready),
        .req_fu      (req_fu),
        .grant_ready (grant_ready),
        .flush       (flush),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .grant_fu    (grant_fu),
        .fu_busy     (fu_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_valid   = 1'b0;
    int m_idx     = 0;
    int m_fu      = 0;
    int m_ptr     = 0;
    int m_busy[3] = '{0, 0, 0};
    int lat[3]    = '{1, 1, 3};

    always @(posedge clk or posedge reset) begin
        bit fire;
        bit avail[4];
        bit pending;
        int pick;
        int pick_fu;
        int nb[3];
        int idx;
        int code;
        if (reset) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_fu    <= 0;
            m_ptr   <= 0;
            for (int f = 0; f < 3; f++) m_busy[f] <= 0;
        end else begin
            fire = m_valid && grant_ready && !flush;
            if (fire) $display("issue entry=%0d fu=%0d t=%0t", m_idx, m_fu, $time);
            for (int f = 0; f < 3; f++) begin
                pending  = m_valid && !fire && m_fu == f;
                avail[f] = (m_busy[f] == 0) && !pending;
                if (fire && m_fu == f && lat[f] != 1) avail[f] = 1'b0;
                nb[f] = (fire && m_fu == f) ? lat[f] - 1 : (m_busy[f] > 0 ? m_busy[f] - 1 : 0);
            end
            avail[3] = 1'b0;
            pick = -1;
            pick_fu = 0;
            if (!flush && (!m_valid || fire)) begin
                for (int k = 0; k < 64; k++) begin
                    idx  = (m_ptr + k) % 64;
                    code = int'(req_fu[2*idx +: 2]);
                    if (pick < 0 && req_ready[idx] && code != 3 && avail[code] &&
                        !(m_valid && m_idx == idx)) begin
                        pick    = idx;
                        pick_fu = code;
                    end
                end
            end
            for (int f = 0; f < 3; f++) m_busy[f] <= nb[f];
            if (flush) begin
                m_valid <= 1'b0;
            end else if (!m_valid || fire) begin
                m_valid <= (pick >= 0);
                if (pick >= 0) begin
                    m_idx <= pick;
                    m_fu  <= pick_fu;
                    m_ptr <= (pick + 1) % 64;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_valid", int'(grant_valid), int'(m_valid));
        if (m_valid) begin
            check("model_index", int'(grant_index), m_idx);
            check("model_fu", int'(grant_fu), m_fu);
        end
        for (int f = 0; f < 3; f++)
            check($sformatf("model_fu_busy%0d", f), int'(fu_busy[f]), int'(m_busy[f] != 0));
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_req();
        req_ready = '0;
        req_fu    = '0;
    endtask

    task automatic set_req(input int i, input int code);
        req_ready[i]     = 1'b1;
        req_fu[2*i +: 2] = code[1:0];
    endtask

    task automatic expect_grant(input string tag, input int v, input int idx, input int fu);
        check({tag, "_valid"}, int'(grant_valid), v);
        if (v != 0) begin
            check({tag, "_index"}, int'(grant_index), idx);
            check({tag, "_fu"}, int'(grant_fu), fu);
        end
    endtask

    initial begin
        reset       = 1'b1;
        grant_ready = 1'b1;
        flush       = 1'b0;
        clear_req();
        repeat (2) @(negedge clk);
        expect_grant("reset", 0, 0, 0);
        check("reset_index", int'(grant_index), 0);
        check("reset_fu_busy", int'(fu_busy), 0);
        check("reset_ptr", int'(dut.rr_ptr_reg), 0);
        reset = 1'b0;

        // Two FU0 requests from pointer 0: 3 then 10, pointer ends at 11.
        set_req(3, 0);
        set_req(10, 0);
        @(negedge clk);
        expect_grant("rr_first", 1, 3, 0);
        req_ready[3] = 1'b0;
        @(negedge clk);
        expect_grant("rr_second", 1, 10, 0);
        check("rr_ptr_dut", int'(dut.rr_ptr_reg), 11);
        check("rr_ptr_model", m_ptr, 11);
        clear_req();
        @(negedge clk);
        expect_grant("rr_idle", 0, 0, 0);

        // Move the pointer to 62, then requests at 1 and 63 wrap correctly.
        set_req(61, 1);
        @(negedge clk);
        expect_grant("wrap_setup", 1, 61, 1);
        check("wrap_ptr62", int'(dut.rr_ptr_reg), 62);
        clear_req();
        set_req(1, 0);
        set_req(63, 0);
        @(negedge clk);
        expect_grant("wrap_hi", 1, 63, 0);
        check("wrap_ptr0", int'(dut.rr_ptr_reg), 0);
        req_ready[63] = 1'b0;
        @(negedge clk);
        expect_grant("wrap_lo", 1, 1, 0);
        clear_req();
        @(negedge clk);
        expect_grant("wrap_idle", 0, 0, 0);

        // FU2 occupancy: busy two cycles, waiting entry 5 granted right after.
        set_req(7, 2);
        @(negedge clk);
        expect_grant("fu2_first", 1, 7, 2);
        clear_req();
        set_req(5, 2);
        @(negedge clk);
        expect_grant("fu2_wait1", 0, 0, 0);
        check("fu2_busy1", int'(fu_busy), 3'b100);
        @(negedge clk);
        expect_grant("fu2_wait2", 0, 0, 0);
        check("fu2_busy2", int'(fu_busy), 3'b100);
        @(negedge clk);
        expect_grant("fu2_wait3", 0, 0, 0);
        check("fu2_busy_clear", int'(fu_busy), 3'b000);
        @(negedge clk);
        expect_grant("fu2_second", 1, 5, 2);
        clear_req();
        @(negedge clk);
        check("fu2_busy_again", int'(fu_busy), 3'b100);
        repeat (3) @(negedge clk);

        // Back-pressure: grant held stable for four cycles, no second grant.
        grant_ready = 1'b0;
        set_req(20, 1);
        set_req(21, 0);
        @(negedge clk);
        expect_grant("hold_0", 1, 20, 1);
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            expect_grant($sformatf("hold_%0d", c), 1, 20, 1);
        end
        grant_ready  = 1'b1;
        req_ready[20] = 1'b0;
        @(negedge clk);
        expect_grant("hold_next", 1, 21, 0);
        clear_req();
        @(negedge clk);
        expect_grant("hold_idle", 0, 0, 0);

        // Flush of a pending FU2 grant: no fire, no counter load, pointer
        // unchanged; entry 40 with the invalid unit code is never granted.
        set_req(30, 2);
        set_req(40, 3);
        @(negedge clk);
        expect_grant("flush_pre", 1, 30, 2);
        req_ready[30] = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        expect_grant("flush_drop", 0, 0, 0);
        check("flush_no_load", int'(fu_busy), 3'b000);
        check("flush_ptr", int'(dut.rr_ptr_reg), 31);
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            expect_grant($sformatf("invalid_fu_%0d", c), 0, 0, 0);
        end
        clear_req();

        // Flush while FU2 is counting down leaves the counter alone.
        set_req(32, 2);
        @(negedge clk);
        expect_grant("flush2_pre", 1, 32, 2);
        clear_req();
        @(negedge clk);
        check("flush2_busy", int'(fu_busy), 3'b100);
        set_req(33, 0);
        @(negedge clk);
        expect_grant("flush2_grant", 1, 33, 0);
        req_ready[33] = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        expect_grant("flush2_drop", 0, 0, 0);
        check("flush2_ptr", int'(dut.rr_ptr_reg), 34);
        flush = 1'b0;
        clear_req();
        @(negedge clk);

        // Asynchronous reset in the middle of a pending grant.
        grant_ready = 1'b0;
        set_req(50, 0);
        @(negedge clk);
        expect_grant("rst_pre", 1, 50, 0);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", int'(grant_valid), 0);
        check("rst_async_index", int'(grant_index), 0);
        check("rst_async_fu", int'(grant_fu), 0);
        check("rst_async_busy", int'(fu_busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_req();
        grant_ready = 1'b1;
        set_req(0, 0);
        @(negedge clk);
        expect_grant("rst_after", 1, 0, 0);
        clear_req();
        @(negedge clk);
        expect_grant("rst_idle", 0, 0, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
